// File: rtl/tick_timer_arbiter.sv
// tick_timer_arbiter: round-robin arbiter sharing one tick-driven down-counter among NUM_REQ requesters.
module tick_timer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*CNT_W-1:0]   delay,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt, win_delay;
  logic [IW-1:0] idx, last, win;
  always_comb begin
    win = last;
    for (int i = NUM_REQ; i >= 1; i--)
      if (req[(int'(last) + i) % NUM_REQ]) win = IW'((int'(last) + i) % NUM_REQ);
    win_delay = delay[int'(win)*CNT_W +: CNT_W];
  end
  // A zero delay enters DONE with grant still high; DONE then spends one more cycle issuing the pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      done <= '0;
      busy <= 1'b0;
      cnt <= '0;
      idx <= '0;
      last <= IW'(NUM_REQ - 1);
    end else begin
      done <= '0;
      case (state)
        IDLE: if (|req) begin
          cnt <= win_delay;
          idx <= win;
          last <= win;
          grant <= NUM_REQ'(1) << win;
          busy <= 1'b1;
          state <= win_delay == '0 ? DONE : RUN;
        end
        RUN: if (!req[idx]) begin
          grant <= '0;
          busy <= 1'b0;
          state <= IDLE;
        end else if (tick && cnt == CNT_W'(1)) begin
          grant <= '0;
          done <= NUM_REQ'(1) << idx;
          state <= DONE;
        end else if (tick) cnt <= cnt - CNT_W'(1);
        DONE: if (|grant) begin
          grant <= '0;
          done <= NUM_REQ'(1) << idx;
        end else begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/tick_timer_arbiter.md
# tick_timer_arbiter

Shared delay-timer controller for the tick domain. Several requesters (I2C bit-timing, debounce, game-step logic) each request a delay measured in base ticks from the existing tick generator. Rather than instantiating one counter per requester, this block arbitrates them round-robin onto a single down-counter. It sequences that counter and returns a one-cycle done pulse to the winning requester.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- CNT_W, 16, width of each delay value in ticks
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- tick  in  1  one-cycle base tick pulse from the tick generator
- req  in  NUM_REQ  per-requester request level, held until done or abort
- delay  in  NUM_REQ*CNT_W  packed delay values; requester i uses bits [i*CNT_W +: CNT_W]
- grant  out  NUM_REQ  one-hot, high while requester owns the timer
- done  out  NUM_REQ  one-cycle pulse to the owner when its delay expires
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- Internal state: cnt[CNT_W-1:0], owner index idx, and round-robin pointer last.
- IDLE, no req bit set: remain in IDLE; grant=0, done=0.
- IDLE, any req bit set:
  - Winner is the first set req bit searching from (last+1) mod NUM_REQ upward, with wrap-around.
  - Latch cnt=delay[winner], idx=winner, last=winner.
  - Set grant[winner]=1.
  - If the latched delay is 0, go to DONE; otherwise go to RUN.
- RUN:
  - req[idx]=0 (abort): go to IDLE, grant=0, no done pulse. Abort has priority over tick in the same cycle.
  - Otherwise, on tick=1 with cnt==1: go to DONE.
  - Otherwise, on tick=1: cnt=cnt-1.
  - Otherwise: hold.
- DONE: done[idx]=1 for exactly one cycle, grant=0, then go to IDLE.
- A requester must drop req after seeing done. If req is still high in IDLE, it is re-arbitrated as a new request; round-robin still favours the other requesters.
- delay is sampled only in the grant cycle. Later changes to delay have no effect on the running count.
- cnt never underflows. The value 0 is handled only by the IDLE-to-DONE path.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, grant=0, done=0, busy=0, cnt=0, idx=0, last=NUM_REQ-1 (requester 0 has first priority).
- Reset asserted mid-RUN: all outputs clear immediately; no done pulse is issued.
- Request to grant: req sampled high in IDLE at edge k makes grant and busy high after edge k.
- A tick coincident with the grant edge is not counted. Counting begins with the first tick sampled in RUN.
- Delay N≥1: done is high in the cycle following the edge that samples the Nth counted tick. grant falls on that same edge.
- Delay 0: done is high the cycle after grant, i.e. 2 cycles after req is sampled.
- Back-to-back service: after DONE, at least one IDLE cycle precedes the next grant. Minimum period between grants is 3 cycles for delay 0.
- Abort: grant and busy fall one cycle after req[idx] is sampled low.
- busy=1 in RUN and DONE; busy=0 in IDLE.

## Test plan
- Single request: req[0]=1, delay0=3, tick every 5 cycles -> grant=4'b0001 next cycle; done[0] pulses exactly once, one cycle after the 3rd tick; busy=0 one cycle later.
- Round-robin: req=4'b1111 held, all delays=1 -> grant order 0,1,2,3,0; each done pulse lands on the correct bit.
- Delay 0: req[2]=1, delay2=0, no ticks -> grant[2] for one cycle, then done[2] for one cycle; no tick is required.
- Abort: req[1]=1, delay1=10; drop req[1] after 4 ticks -> grant falls next cycle; no done pulse; a subsequent req[3] is granted from IDLE.
- Tick coincident with grant and abort coincident with tick: tick in the grant cycle -> not counted (delay 2 needs 2 later ticks); abort plus tick in RUN -> IDLE with no done pulse.
- Async reset mid-RUN: drive reset=0 between clock edges -> grant, done and busy are 0 immediately; after release, req[0] is granted before req[3] when both are set.
